puf_serial_controller: RTL and testbench

Sequencing controller for the serial PUF path. Loads a seed into the external 8-bit challenge LFSR, steps it once per response bit, hands each challenge to the ring-oscillator PUF core with a start/done handshake, and assembles the returned bits into a NUM_BITS-wide response word. The word is offered to the host with a valid/ready handshake. Sits between the host/UART front end and the LFSR plus RO-compare core.

---
 rtl/puf_serial_controller.sv | 174 +++++++++++++++++
 tb/tb_puf_serial_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_serial_controller.sv
// Sequencing controller for the serial ring-oscillator PUF path.
// Seeds and steps the external challenge LFSR, runs one start/done measurement
// per response bit and offers the assembled word to the host over valid/ready.
module puf_serial_controller #(
    parameter int CHAL_WIDTH     = 8,
    parameter int NUM_BITS       = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CHAL_WIDTH-1:0] seed,
    output logic                  lfsr_load,
    output logic [CHAL_WIDTH-1:0] lfsr_seed,
    output logic                  lfsr_step,
    input  logic [CHAL_WIDTH-1:0] challenge,
    output logic [CHAL_WIDTH-1:0] puf_challenge,
    output logic                  puf_start,
    input  logic                  puf_done,
    input  logic                  puf_bit,
    output logic [NUM_BITS-1:0]   response,
    output logic                  response_valid,
    input  logic                  response_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BITS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        WAIT    = 3'd4,
        STEP    = 3'd5,
        HOLD    = 3'd6
    } state_t;

    state_t                state_reg, state_next;
    logic [CHAL_WIDTH-1:0] seed_reg, seed_next;
    logic [CHAL_WIDTH-1:0] chal_reg, chal_next;
    logic [NUM_BITS-1:0]   resp_reg, resp_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [SET_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [TO_W-1:0]       timeout_cnt_reg, timeout_cnt_next;
    logic                  error_reg, error_next;

    // Pulse and status outputs are flops loaded from the next state, so each
    // one is high exactly while the FSM sits in the matching state.
    logic lfsr_load_reg, lfsr_step_reg, puf_start_reg, valid_reg, busy_reg;

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            seed_reg        <= '0;
            chal_reg        <= '0;
            resp_reg        <= '0;
            idx_reg         <= '0;
            settle_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
            error_reg       <= 1'b0;
            lfsr_load_reg   <= 1'b0;
            lfsr_step_reg   <= 1'b0;
            puf_start_reg   <= 1'b0;
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            seed_reg        <= seed_next;
            chal_reg        <= chal_next;
            resp_reg        <= resp_next;
            idx_reg         <= idx_next;
            settle_cnt_reg  <= settle_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            error_reg       <= error_next;
            lfsr_load_reg   <= (state_next == LOAD);
            lfsr_step_reg   <= (state_next == STEP);
            puf_start_reg   <= (state_next == MEASURE);
            valid_reg       <= (state_next == HOLD);
            busy_reg        <= (state_next != IDLE);
        end
    end

    // Next-state and datapath update for the measurement sequence.
    always_comb begin
        state_next       = state_reg;
        seed_next        = seed_reg;
        chal_next        = chal_reg;
        resp_next        = resp_reg;
        idx_next         = idx_reg;
        settle_cnt_next  = settle_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        error_next       = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    seed_next  = seed;
                    resp_next  = '0;
                    idx_next   = '0;
                    error_next = 1'b0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                settle_cnt_next = '0;
                state_next      = SETTLE;
            end
            SETTLE: begin
                // The LFSR output has had time to propagate through the RO mux
                // by the last settle edge, so that is where it is captured.
                if (settle_cnt_reg == SETTLE_LAST) begin
                    chal_next  = challenge;
                    state_next = MEASURE;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            MEASURE: begin
                timeout_cnt_next = '0;
                state_next       = WAIT;
            end
            WAIT: begin
                // A done on the same edge as the timeout still counts.
                if (puf_done) begin
                    resp_next[idx_reg] = puf_bit;
                    if (idx_reg == LAST_IDX) begin
                        state_next = HOLD;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = STEP;
                    end
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 1'b1;
                end
            end
            STEP: begin
                settle_cnt_next = '0;
                state_next      = SETTLE;
            end
            HOLD: begin
                if (response_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign lfsr_load      = lfsr_load_reg;
    assign lfsr_seed      = seed_reg;
    assign lfsr_step      = lfsr_step_reg;
    assign puf_challenge  = chal_reg;
    assign puf_start      = puf_start_reg;
    assign response       = resp_reg;
    assign response_valid = valid_reg;
    assign busy           = busy_reg;
    assign error          = error_reg;

endmodule

// File: tb/tb_puf_serial_controller.sv
// Testbench for puf_serial_controller: external LFSR model, PUF responder and
// a per-cycle checker that predicts challenges, timing and response words.
module tb_puf_serial_controller;

    localparam int CW = 8;
    localparam int NB = 4;
    localparam int SC = 2;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] seed = '0;
    logic          lfsr_load;
    logic [CW-1:0] lfsr_seed;
    logic          lfsr_step;
    logic [CW-1:0] challenge;
    logic [CW-1:0] puf_challenge;
    logic          puf_start;
    logic          puf_done = 1'b0;
    logic          puf_bit = 1'b0;
    logic [NB-1:0] response;
    logic          response_valid;
    logic          response_ready = 1'b0;
    logic          busy;
    logic          error;

    puf_serial_controller #(
        .CHAL_WIDTH(CW), .NUM_BITS(NB), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .seed(seed),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
        .challenge(challenge), .puf_challenge(puf_challenge), .puf_start(puf_start),
        .puf_done(puf_done), .puf_bit(puf_bit), .response(response),
        .response_valid(response_valid), .response_ready(response_ready),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // External 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [CW-1:0] lfsr_q;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)       lfsr_q <= '0;
        else if (lfsr_load) lfsr_q <= lfsr_seed;
        else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign challenge = lfsr_q;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model / checker state
    logic [CW-1:0] cur_seed = '0;
    logic [CW-1:0] exp_chal = '0;
    logic [CW-1:0] chal_log[$];
    int            since = 0;
    int            step_cnt = 0;
    int            load_cnt = 0;
    logic          prev_valid = 1'b0;
    logic [NB-1:0] prev_resp = '0;
    // Responder state
    logic [NB-1:0] rsp_bits = '0;
    logic [NB-1:0] model_resp = '0;
    int            rsp_idx = 0;
    int            rsp_delay = 3;
    int            rsp_cnt = 0;
    logic          rsp_pend = 1'b0;
    int            spur_cnt = 0;

    // One clock of the bench: check DUT outputs, then drive the PUF inputs.
    task automatic tick();
        @(negedge clock);
        if (!reset_n) begin
            puf_done   = 1'b0;
            puf_bit    = 1'b0;
            rsp_pend   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (lfsr_load) begin
                load_cnt++;
                step_cnt = 0;
                since    = 0;
                exp_chal = cur_seed;
                chal_log.delete();
                check("lfsr_seed", lfsr_seed, cur_seed);
            end else if (lfsr_step) begin
                step_cnt++;
                since = 0;
            end else begin
                since++;
            end
            if (puf_start) begin
                check("settle_latency", since, SC + 1);
                check("puf_challenge", puf_challenge, exp_chal);
                chal_log.push_back(puf_challenge);
                exp_chal = lfsr_next(exp_chal);
            end
            if (response_valid && !prev_valid) begin
                check("response_word", response, model_resp);
                check("steps_per_run", step_cnt, NB - 1);
                $display("run seed=%02h response=%01h steps=%0d", cur_seed, response, step_cnt);
            end
            if (response_valid && prev_valid)
                check("response_stable", response, prev_resp);
            prev_valid = response_valid;
            prev_resp  = response;

            puf_done = 1'b0;
            puf_bit  = 1'b0;
            if (lfsr_load) begin
                rsp_idx    = 0;
                model_resp = '0;
            end
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_pend = 1'b0;
                    puf_done = 1'b1;
                    if (rsp_idx < NB) begin
                        puf_bit             = rsp_bits[rsp_idx];
                        model_resp[rsp_idx] = rsp_bits[rsp_idx];
                    end
                    rsp_idx++;
                end
            end
            if (puf_start && rsp_delay != 0) begin
                rsp_pend = 1'b1;
                rsp_cnt  = rsp_delay;
            end
            if (spur_cnt > 0) begin
                puf_done = 1'b1;
                puf_bit  = 1'b1;
                spur_cnt--;
            end
        end
    endtask

    task automatic start_run(input logic [CW-1:0] s);
        cur_seed = s;
        seed     = s;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_pstart(input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!puf_start && n < limit);
        check("wait_puf_start", puf_start, 1'b1);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!response_valid && n < limit) begin
            tick();
            n++;
        end
        check("wait_response_valid", response_valid, 1'b1);
    endtask

    task automatic accept();
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        check("accept_valid", response_valid, 1'b0);
        check("accept_busy", busy, 1'b0);
    endtask

    task automatic check_chals(input logic [7:0] c0, input logic [7:0] c1,
                               input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] exp_c[4];
        exp_c = '{c0, c1, c2, c3};
        check("chal_count", chal_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < chal_log.size()) check("chal_literal", chal_log[i], exp_c[i]);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_valid", response_valid, 0);
        check("rst_pulses", {lfsr_load, lfsr_step, puf_start}, 0);
        check("rst_data", {lfsr_seed, puf_challenge, response}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Full run, seed 01, bits 1,0,1,1
        rsp_bits = 4'b1101; rsp_delay = 3; load_cnt = 0;
        start_run(8'h01);
        check("t1_load_pulse", lfsr_load, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_load_once", {lfsr_load, puf_start}, 0);
        tick();
        check("t1_no_start_early", puf_start, 0);
        tick();
        check("t1_puf_start_e3", puf_start, 1);
        wait_valid(100);
        check("t1_response", response, 4'b1101);
        check_chals(8'h01, 8'h02, 8'h04, 8'h08);
        check("t1_loads", load_cnt, 1);
        check("t1_steps", step_cnt, 3);

        // Backpressure with start pulses during HOLD
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            tick();
            check("bp_valid_held", response_valid, 1);
        end
        start = 1'b0;
        check("bp_start_ignored", load_cnt, 1);
        check("bp_response", response, 4'b1101);
        response_ready = 1'b1;
        start = 1'b1;
        tick();
        response_ready = 1'b0;
        start = 1'b0;
        check("bp_release_valid", response_valid, 0);
        check("bp_release_busy", busy, 0);
        tick();
        tick();
        check("bp_start_same_cycle_ignored", load_cnt, 1);
        check("bp_response_kept", response, 4'b1101);

        // Spurious done in IDLE
        spur_cnt = 3;
        repeat (4) tick();
        check("spur_idle_resp", response, 4'b1101);
        check("spur_idle_busy", busy, 0);

        // Spurious done during SETTLE
        rsp_bits = 4'b0110;
        start_run(8'h01);
        spur_cnt = 2;
        wait_valid(100);
        check("spur_settle_resp", response, 4'b0110);
        accept();

        // Timeout: PUF never answers
        rsp_delay = 0;
        start_run(8'h01);
        wait_pstart(20);
        repeat (8) tick();
        check("to_busy_before", busy, 1);
        check("to_error_before", error, 0);
        tick();
        check("to_busy_after", busy, 0);
        check("to_error_after", error, 1);
        check("to_valid", response_valid, 0);
        repeat (3) tick();
        check("to_error_sticky", error, 1);
        check("to_valid_idle", response_valid, 0);
        rsp_delay = 3; rsp_bits = 4'b1001;
        start_run(8'h3C);
        check("to_error_cleared", error, 0);
        wait_valid(100);
        check("to_next_resp", response, 4'b1001);
        accept();

        // Done arriving on the timeout edge
        rsp_delay = 8; rsp_bits = 4'b1010;
        start_run(8'h01);
        wait_valid(200);
        check("edge_error", error, 0);
        check("edge_resp", response, 4'b1010);
        accept();

        // Reset during WAIT of bit 2
        rsp_delay = 3; rsp_bits = 4'b1111;
        start_run(8'h5A);
        wait_pstart(20);
        wait_pstart(20);
        wait_pstart(20);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_flags", {busy, error, response_valid}, 0);
        check("mid_rst_pulses", {lfsr_load, lfsr_step, puf_start}, 0);
        check("mid_rst_data", {lfsr_seed, puf_challenge, response}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        rsp_bits = 4'b0011;
        start_run(8'hA5);
        wait_valid(100);
        check("post_rst_resp", response, 4'b0011);
        check_chals(8'hA5, 8'h4A, 8'h95, 8'h2A);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
